cbd_sample_scheduler: RTL and testbench

Sequences the CBD sampler over a batch of polynomials: drives its `start`, `n_coeffs` and `eta` inputs, and accepts its coefficient stream. It writes each coefficient into polynomial RAM at `{slot, index}`. It sits between the Kyber top-level controller, which issues jobs such as "k polys at eta1, then k+1 polys at eta2", and the sampler/RAM pair.

---
 rtl/cbd_sample_scheduler_pkg.sv | 21 ++
 rtl/cbd_sample_scheduler_modq.sv | 22 ++
 rtl/cbd_sample_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_cbd_sample_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbd_sample_scheduler_pkg.sv
// Shared types and constants for the CBD sample scheduler.
// The mod-q write mapping is selected by CBD_SCHED_MODQ_EN (see cbd_coeff_modq).
package cbd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sched_state_e;

    localparam logic [11:0] KYBER_Q = 12'd3329;
    localparam logic [3:0]  ETA2    = 4'd2;
    localparam logic [3:0]  ETA3    = 4'd3;

    function automatic logic [11:0] sext_coeff(input logic signed [3:0] d);
        return {{8{d[3]}}, d};
    endfunction

endpackage

// File: rtl/cbd_sample_scheduler_modq.sv
// Maps a signed 4-bit CBD coefficient to a 12-bit RAM word.
// CBD_SCHED_MODQ_EN defined: reduce into [0, q); otherwise plain sign extension.
module cbd_coeff_modq (
    input  logic signed [3:0]  coeff,
    output logic        [11:0] wdata
);
    import cbd_sched_pkg::*;

`ifdef CBD_SCHED_MODQ_EN
    // Negative inputs are small, so q + d never leaves the 12-bit range.
    function automatic logic [11:0] reduce_q(input logic signed [3:0] d);
        logic [11:0] ext;
        ext = sext_coeff(d);
        return d[3] ? (KYBER_Q + ext) : ext;
    endfunction

    assign wdata = reduce_q(coeff);
`else
    assign wdata = sext_coeff(coeff);
`endif

endmodule

// File: rtl/cbd_sample_scheduler.sv
// Runs the CBD sampler over a batch of polynomials and writes each coefficient
// to polynomial RAM at {slot, index}. Write-data mapping set by CBD_SCHED_MODQ_EN.
module cbd_sample_scheduler #(
    parameter int POLY_LENGTH         = 256,
    parameter int COEFF_COUNTER_WIDTH = 16,
    parameter int SLOT_W              = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     job_valid,
    output logic                                     job_ready,
    input  logic [3:0]                               job_n_eta1,
    input  logic [3:0]                               job_n_eta2,
    input  logic [3:0]                               job_eta1,
    input  logic [3:0]                               job_eta2,
    input  logic [SLOT_W-1:0]                        job_base,
    input  logic                                     abort,
    output logic                                     samp_start,
    output logic [COEFF_COUNTER_WIDTH-1:0]           samp_n_coeffs,
    output logic [3:0]                               samp_eta,
    input  logic                                     samp_coeff_valid,
    input  logic signed [3:0]                        samp_coeff_data,
    input  logic                                     samp_coeff_last,
    output logic                                     samp_coeff_ready,
    output logic                                     mem_we,
    output logic [SLOT_W+$clog2(POLY_LENGTH)-1:0]    mem_addr,
    output logic [11:0]                              mem_wdata,
    input  logic                                     mem_ready,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err
);
    import cbd_sched_pkg::*;

    localparam int             IDX_W    = $clog2(POLY_LENGTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(POLY_LENGTH - 1);

    sched_state_e state, next_state;

    logic [3:0]        n_eta1_q;
    logic [3:0]        n_eta2_q;
    logic [3:0]        eta1_q;
    logic [3:0]        eta2_q;
    logic [SLOT_W-1:0] base_q;
    logic [4:0]        poly_idx;
    logic [IDX_W-1:0]  coeff_idx;
    logic              err_q;

    logic              job_fire;
    logic              coeff_hs;
    logic              last_poly;
    logic              in_flow;
    logic [4:0]        n_total;
    logic [4:0]        job_total;
    logic [SLOT_W-1:0] slot;
    logic [11:0]       mapped_wdata;

    assign job_fire  = job_valid & job_ready;
    assign coeff_hs  = samp_coeff_valid & samp_coeff_ready;
    assign in_flow   = (state == STREAM) || (state == DRAIN);
    assign n_total   = {1'b0, n_eta1_q} + {1'b0, n_eta2_q};
    assign job_total = {1'b0, job_n_eta1} + {1'b0, job_n_eta2};
    assign last_poly = (poly_idx == (n_total - 5'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (job_fire) begin
                    next_state = (job_total == 5'd0) ? DONE : START;
                end
            end
            START: begin
                next_state = abort ? IDLE : STREAM;
            end
            STREAM: begin
                // A final handshake wins over a simultaneous abort: it still completes.
                if (coeff_hs && samp_coeff_last) begin
                    next_state = last_poly ? DONE : START;
                end else if (abort) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (coeff_hs && samp_coeff_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        job_ready        = 1'b0;
        samp_start       = 1'b0;
        samp_coeff_ready = 1'b0;
        mem_we           = 1'b0;
        done             = 1'b0;
        busy             = 1'b1;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
            end
            START: begin
                samp_start = ~abort;
            end
            STREAM: begin
                samp_coeff_ready = mem_ready;
                mem_we           = samp_coeff_valid;
            end
            DRAIN: begin
                samp_coeff_ready = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Job capture, poly/coefficient counters and the sticky length-mismatch flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_eta1_q  <= '0;
            n_eta2_q  <= '0;
            eta1_q    <= '0;
            eta2_q    <= '0;
            base_q    <= '0;
            poly_idx  <= '0;
            coeff_idx <= '0;
            err_q     <= 1'b0;
        end else begin
            if (job_fire) begin
                n_eta1_q  <= job_n_eta1;
                n_eta2_q  <= job_n_eta2;
                eta1_q    <= job_eta1;
                eta2_q    <= job_eta2;
                base_q    <= job_base;
                poly_idx  <= '0;
                coeff_idx <= '0;
                err_q     <= 1'b0;
            end
            if (state == START) begin
                coeff_idx <= '0;
            end
            if (in_flow && coeff_hs) begin
                coeff_idx <= coeff_idx + 1'b1;
                if (samp_coeff_last != (coeff_idx == IDX_LAST)) begin
                    err_q <= 1'b1;
                end
                if ((state == STREAM) && samp_coeff_last) begin
                    poly_idx <= poly_idx + 5'd1;
                end
            end
        end
    end

    assign slot          = base_q + SLOT_W'(poly_idx);
    assign mem_addr      = {slot, coeff_idx};
    assign samp_eta      = (poly_idx < {1'b0, n_eta1_q}) ? eta1_q : eta2_q;
    assign samp_n_coeffs = COEFF_COUNTER_WIDTH'(POLY_LENGTH);
    assign err           = err_q;

    cbd_coeff_modq u_modq (
        .coeff (samp_coeff_data),
        .wdata (mapped_wdata)
    );

    assign mem_wdata = mem_we ? mapped_wdata : 12'd0;

endmodule

// File: tb/tb_cbd_sample_scheduler.sv
// Randomized bench for cbd_sample_scheduler: a behavioural sampler/RAM model plus
// an expected-write list derived from each job description.
module tb_cbd_sample_scheduler;

    localparam int PL = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid;
    logic              job_ready;
    logic [3:0]        job_n_eta1, job_n_eta2, job_eta1, job_eta2;
    logic [3:0]        job_base;
    logic              abort;
    logic              samp_start;
    logic [15:0]       samp_n_coeffs;
    logic [3:0]        samp_eta;
    logic              samp_coeff_valid;
    logic signed [3:0] samp_coeff_data;
    logic              samp_coeff_last;
    logic              samp_coeff_ready;
    logic              mem_we;
    logic [11:0]       mem_addr;
    logic [11:0]       mem_wdata;
    logic              mem_ready;
    logic              busy, done, err;

    always #5 clk = ~clk;

    cbd_sample_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_n_eta1       (job_n_eta1),
        .job_n_eta2       (job_n_eta2),
        .job_eta1         (job_eta1),
        .job_eta2         (job_eta2),
        .job_base         (job_base),
        .abort            (abort),
        .samp_start       (samp_start),
        .samp_n_coeffs    (samp_n_coeffs),
        .samp_eta         (samp_eta),
        .samp_coeff_valid (samp_coeff_valid),
        .samp_coeff_data  (samp_coeff_data),
        .samp_coeff_last  (samp_coeff_last),
        .samp_coeff_ready (samp_coeff_ready),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int  cyc = 0;
    int  seed;
    int  samp_active = 0, samp_poly = 0, samp_idx = 0, samp_len = PL;
    int  bad_poly = -1, bad_len = PL, abort_poly = -1, abort_coeff = 0;
    bit  aborted = 0, abort_wrote = 0, bp_en = 0, gap_en = 0;
    int  act_addr[$], act_data[$], start_eta[$];
    int  done_cnt, last_cyc, done_cyc, start_overlap, rdy_err, drain_err;
    bit  p_hs = 0, p_last = 0, p_we = 0, p_start = 0;
    int  p_addr = 0, p_data = 0, p_eta = 0;

    function automatic int coef(input int p, input int i);
        return ((p * 131 + i * 29 + seed) % 7) - 3;
    endfunction

    function automatic int map_q(input int d);
`ifdef CBD_SCHED_MODQ_EN
        return (d < 0) ? 3329 + d : d;
`else
        return (d < 0) ? 4096 + d : d;
`endif
    endfunction

    // One clock of the sampler/RAM model; entered and left just after a falling edge.
    task automatic step();
        bit draining;
        cyc++;
        if (p_hs) begin
            if (p_last) samp_active = 0;
            else        samp_idx++;
        end
        if (p_we) begin
            act_addr.push_back(p_addr);
            act_data.push_back(p_data);
        end
        if (p_start) begin
            if (samp_active != 0) start_overlap++;
            start_eta.push_back(p_eta);
            samp_active = 1;
            samp_idx    = 0;
            samp_len    = (samp_poly == bad_poly) ? bad_len : PL;
            samp_poly++;
        end
        draining  = aborted;
        abort     = 1'b0;
        mem_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (samp_active != 0) begin
            samp_coeff_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            samp_coeff_data  = 4'(coef(samp_poly - 1, samp_idx));
            samp_coeff_last  = (samp_idx == samp_len - 1);
        end else begin
            samp_coeff_valid = 1'b0;
            samp_coeff_last  = 1'b0;
            samp_coeff_data  = 4'($urandom_range(0, 15));
        end
        if (abort_poly >= 0 && !aborted && samp_active != 0 &&
            samp_poly - 1 == abort_poly && samp_idx == abort_coeff) begin
            abort       = 1'b1;
            aborted     = 1'b1;
            abort_wrote = samp_coeff_valid & mem_ready;
        end
        #1;
        if (samp_active != 0) begin
            if (draining) begin
                if (samp_coeff_ready !== 1'b1) drain_err++;
            end else if (samp_coeff_ready !== mem_ready) begin
                rdy_err++;
            end
        end
        p_hs    = samp_coeff_valid & samp_coeff_ready;
        p_last  = samp_coeff_last;
        p_we    = mem_we & mem_ready;
        p_addr  = int'(mem_addr);
        p_data  = int'(mem_wdata);
        p_start = samp_start;
        p_eta   = int'(samp_eta);
        if (p_hs && p_last) last_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic run_job(input int n1, input int n2, input int e1, input int e2,
                           input int base, input int ap, input int ac,
                           input int bpoly, input int blen, input bit bpe, input bit ge);
        int n, exp_starts, em, k, wm, slot, cnt;
        seed = $urandom_range(0, 999);
        abort_poly = ap; abort_coeff = ac; bad_poly = bpoly; bad_len = blen;
        bp_en = bpe; gap_en = ge; aborted = 0; abort_wrote = 0;
        samp_poly = 0; samp_active = 0;
        act_addr.delete(); act_data.delete(); start_eta.delete();
        done_cnt = 0; rdy_err = 0; drain_err = 0; start_overlap = 0;
        last_cyc = -100; done_cyc = -1;
        n = n1 + n2;

        job_n_eta1 = 4'(n1); job_n_eta2 = 4'(n2);
        job_eta1 = 4'(e1); job_eta2 = 4'(e2); job_base = 4'(base);
        job_valid = 1'b1;
        #1;
        chk("job_ready_idle", job_ready, 1);
        step();
        job_valid = 1'b0;
        #1;
        chk("busy_after_accept", busy, 1);
        chk("job_ready_after_accept", job_ready, 0);
        chk("err_clear_on_accept", err, 0);
        chk("start_after_accept", samp_start, (n > 0));
        chk("done_zero_job", done, (n == 0));

        for (int i = 0; i < 20000 && done_cnt == 0; i++) step();
        chk("done_seen", done_cnt, 1);
        #1;
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);

        exp_starts = (ap >= 0) ? ap + 1 : n;
        chk("start_count", start_eta.size(), exp_starts);
        em = 0;
        for (int p = 0; p < start_eta.size() && p < exp_starts; p++)
            if (start_eta[p] != ((p < n1) ? e1 : e2)) em++;
        chk("eta_sequence", em, 0);

        k = 0; wm = 0;
        for (int p = 0; p < exp_starts; p++) begin
            slot = (base + p) % 16;
            if (p == ap)         cnt = ac + int'(abort_wrote);
            else if (p == bpoly) cnt = blen;
            else                 cnt = PL;
            for (int i = 0; i < cnt; i++) begin
                if (k < act_addr.size())
                    if (act_addr[k] != slot * PL + i || act_data[k] != map_q(coef(p, i))) wm++;
                k++;
            end
        end
        chk("write_count", act_addr.size(), k);
        chk("write_sequence", wm, 0);
        chk("ready_tracks_mem", rdy_err, 0);
        chk("drain_ready", drain_err, 0);
        chk("start_while_active", start_overlap, 0);
        if (n > 0) chk("done_latency", done_cyc - last_cyc, 1);
        chk("err_flag", err, (bpoly >= 0));
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        job_n_eta1 = '0; job_n_eta2 = '0; job_eta1 = '0; job_eta2 = '0; job_base = '0;
        samp_coeff_valid = 1'b0; samp_coeff_data = '0; samp_coeff_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_job_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_samp_start", samp_start, 0);
        chk("rst_coeff_ready", samp_coeff_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_samp_eta", samp_eta, 0);
        chk("rst_n_coeffs", samp_n_coeffs, PL);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single poly, ideal sampler
        run_job(1, 0, 3, 2, 5, -1, 0, -1, PL, 0, 0);
        chk("single_first_addr", (act_addr.size() > 0) ? act_addr[0] : -1, 'h500);
        chk("single_last_addr", (act_addr.size() > 0) ? act_addr[act_addr.size()-1] : -1, 'h5FF);
        // keygen-style job with slot wrap
        run_job(2, 3, 3, 2, 14, -1, 0, -1, PL, 0, 1);
        // backpressure from RAM and sampler gaps
        run_job(2, 1, 2, 3, $urandom_range(0, 15), -1, 0, -1, PL, 1, 1);
        // abort at coefficient 100 of poly 1, then a clean job
        run_job(3, 0, 2, 2, 7, 1, 100, -1, PL, 1, 0);
        run_job(1, 1, 3, 2, 0, -1, 0, -1, PL, 0, 1);
        // early last at coefficient 200, then err must clear
        run_job(2, 0, 2, 2, 3, -1, 0, 0, 201, 0, 0);
        run_job(1, 0, 2, 2, 9, -1, 0, -1, PL, 1, 0);
        // zero-count job
        run_job(0, 0, 3, 3, 4, -1, 0, -1, PL, 0, 0);
        for (int r = 0; r < 2; r++)
            run_job($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(2, 3),
                    $urandom_range(2, 3), $urandom_range(0, 15), -1, 0, -1, PL,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // reset in the middle of a job
        job_n_eta1 = 4'd2; job_n_eta2 = 4'd0; job_base = 4'd1; job_valid = 1'b1;
        bp_en = 0; gap_en = 0; abort_poly = -1; bad_poly = -1; aborted = 0;
        step();
        job_valid = 1'b0;
        repeat (40) step();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midjob_rst_busy", busy, 0);
        chk("midjob_rst_job_ready", job_ready, 1);
        chk("midjob_rst_coeff_ready", samp_coeff_ready, 0);
        rst_n = 1'b1;
        samp_active = 0; p_hs = 0; p_we = 0; p_start = 0;
        @(negedge clk);
        run_job(1, 0, 3, 2, 2, -1, 0, -1, PL, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
